// File: rtl/alsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alsu_ctrl
// Purpose  : Issue/collect controller for the 8-bit combinational ALSU.
//            Accepts a request, drives registered select/operands to the
//            ALSU, optionally re-runs the operation with the result fed
//            back as operand A, and returns the final result and flags.
// Options  : ALSU_CTRL_STICKY_FLAGS_EN - when defined, the response flags
//            are the OR of the carry/overflow flags over all iterations;
//            otherwise they are the flags of the final iteration.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   // request channel
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_cin,
   input  logic [CNT_W-1:0] req_cnt,
   // ALSU drive
   output logic [WIDTH-1:0] alsu_a,
   output logic [WIDTH-1:0] alsu_b,
   output logic             alsu_cin,
   output logic [3:0]       alsu_s,
   // ALSU sample
   input  logic [WIDTH-1:0] alsu_f,
   input  logic             alsu_cout,
   input  logic             alsu_ovf,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_f,
   output logic             rsp_cout,
   output logic             rsp_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] iter;
   logic             accept;
   logic             last_iter;
   logic             fin_cout;
   logic             fin_ovf;

   // req_ready is decoded from state only; no path from req_valid
   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign last_iter = (iter == '0);

`ifdef ALSU_CTRL_STICKY_FLAGS_EN
   logic sticky_cout;
   logic sticky_ovf;

   // Accumulate flags over the iterations of the current operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_cout <= 1'b0;
         sticky_ovf  <= 1'b0;
      end else if (accept) begin
         sticky_cout <= 1'b0;
         sticky_ovf  <= 1'b0;
      end else if (state == EXEC) begin
         sticky_cout <= sticky_cout | alsu_cout;
         sticky_ovf  <= sticky_ovf  | alsu_ovf;
      end
   end

   // The final iteration's flags are folded in as they are sampled
   assign fin_cout = sticky_cout | alsu_cout;
   assign fin_ovf  = sticky_ovf  | alsu_ovf;
`else
   assign fin_cout = alsu_cout;
   assign fin_ovf  = alsu_ovf;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid)  state_nxt = EXEC;
         EXEC: if (last_iter)  state_nxt = RESP;
         RESP: if (rsp_ready)  state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // Operand/select registers, iteration counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alsu_a    <= '0;
         alsu_b    <= '0;
         alsu_cin  <= 1'b0;
         alsu_s    <= 4'd0;
         iter      <= '0;
         rsp_valid <= 1'b0;
         rsp_f     <= '0;
         rsp_cout  <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  alsu_a   <= req_a;
                  alsu_b   <= req_b;
                  alsu_s   <= req_op;
                  alsu_cin <= req_cin;
                  iter     <= req_cnt;
               end
            end
            EXEC: begin
               if (!last_iter) begin
                  // feed the result back for the next pass; B/S/cin held
                  alsu_a <= alsu_f;
                  iter   <= iter - CNT_W'(1);
               end else begin
                  rsp_f     <= alsu_f;
                  rsp_cout  <= fin_cout;
                  rsp_ovf   <= fin_ovf;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/alsu_ctrl.md
# alsu_ctrl

Sequential issue/collect controller for the 8-bit combinational ALSU. It accepts operation requests over a valid/ready handshake and drives the ALSU select, operand and carry-in lines from registers. It samples the ALSU result and flags, optionally iterating the same operation with the result fed back as operand A, and returns the final result over a valid/ready response channel. It sits between the instruction/sequencer logic and the ALSU datapath.

## Interface
- WIDTH, 8: operand/result width; matches the ALSU.
- CNT_W, 3: width of the repeat count; an operation runs req_cnt+1 times.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; equals (state==IDLE).
- req_op  in  4  {s3,s2,s1,s0} ALSU select.
- req_a, req_b  in  WIDTH  operands.
- req_cin  in  1  carry-in, applied on every iteration.
- req_cnt  in  CNT_W  extra iterations (0 = single pass).
- alsu_a, alsu_b  out  WIDTH  registered operands to the ALSU.
- alsu_cin  out  1  registered carry-in.
- alsu_s  out  4  registered select {s3,s2,s1,s0}.
- alsu_f  in  WIDTH  ALSU result.
- alsu_cout, alsu_ovf  in  1  ALSU carry-out and overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_f  out  WIDTH  final result.
- rsp_cout, rsp_ovf  out  1  final flags.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: load the operand and select registers (alsu_a=req_a, alsu_b=req_b, alsu_s=req_op, alsu_cin=req_cin) and iter=req_cnt.
  - Go to EXEC.
- **EXEC**
  - Every cycle, sample alsu_f, alsu_cout and alsu_ovf.
  - If iter≠0: alsu_a←alsu_f, iter←iter−1, stay in EXEC.
  - If iter==0: rsp_f←alsu_f, rsp_cout and rsp_ovf per the Configuration rule, rsp_valid←1, go to RESP.
  - alsu_b, alsu_s and alsu_cin are held constant for the whole operation.
- **RESP**
  - rsp_* are held stable while rsp_valid=1.
  - On rsp_ready: rsp_valid←0, go to IDLE.
- Requests presented while req_ready=0 are ignored and are not queued.
- The controller does no arithmetic of its own. Results wrap at WIDTH bits, as the ALSU produces them.
- Reset values:
  - All alsu_* and rsp_* outputs are 0; rsp_valid=0.
  - State is IDLE, so req_ready=1 while in reset and after release.
- Reset mid-operation (EXEC or RESP): the operation is abandoned, no response is issued, and all outputs return to their reset values immediately.

## Timing
- The request is accepted on the rising edge where req_valid && req_ready; call it edge k.
- Iteration i (1..req_cnt+1) is sampled at edge k+i. The ALSU has one full cycle of combinational settle time per iteration.
- rsp_valid rises at edge k+req_cnt+1, i.e. latency is req_cnt+1 cycles.
- Handshake completes on the edge where rsp_valid && rsp_ready. req_ready is 1 in the following cycle.
- Minimum initiation interval is req_cnt+3 cycles (accept, iterations, response, return to IDLE).
- There is no combinational path from req_valid or rsp_ready to any output except req_ready, which is state-decoded only.

## Configuration
- Macro: ALSU_CTRL_STICKY_FLAGS_EN.
- **Defined:** rsp_cout and rsp_ovf are the OR of alsu_cout and alsu_ovf across all iterations of the operation. The sticky accumulators clear on request accept.
- **Undefined:** rsp_cout and rsp_ovf are the flags of the final iteration only.

## Test plan
The bench drives an ALSU model:
- op 4'b0000: f=a+b+cin, cout=carry, ovf=signed overflow.
- op 4'b1100: f=a<<1, cout=a[7].

Scenarios:
- Reset asserted mid-bench -> req_ready=1; rsp_valid=0; alsu_s=0; rsp_f=0x00, held through reset release.
- Single add: op=0000, a=0x05, b=0x03, cin=0, cnt=0 -> rsp_valid one cycle after accept, rsp_f=0x08, rsp_cout=0.
- Repeat add: a=0x10, b=0x10, cnt=3 -> rsp_f=0x50 after 4 cycles; alsu_a walks 0x10, 0x20, 0x30, 0x40.
- Shift repeat: op=1100, a=0x81, cnt=1 -> rsp_f=0x04, rsp_cout=0. With the macro defined, rsp_cout=1 from the first iteration.
- Add carry: a=0xF0, b=0x10, cnt=1 -> rsp_f=0x10. rsp_cout=0 without the macro, 1 with it.
- Backpressure and abort:
  - Hold rsp_ready=0 for 4 cycles while driving a second request -> rsp_* are stable, req_ready=0, and the second request is dropped.
  - Assert rst_n=0 during EXEC -> no response is issued and rsp_valid stays 0.
